id_token_arbiter: RTL and testbench

//   Shares one identifier-recognizer datapath between two character streams.

---
 rtl/id_token_arbiter.sv | 128 ++++++++++++
 tb/tb_id_token_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_token_arbiter.sv
// id_token_arbiter: shares one identifier recognizer between two character streams.
// Ownership is granted per token (round-robin) and each completed token is reported once.
module id_token_arbiter #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [7:0]       req0_char,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_char,
  output logic             req1_ready,
  output logic [1:0]       grant,
  output logic             tok_valid,
  output logic             tok_src,
  output logic [LEN_W-1:0] tok_len,
  output logic             tok_is_id,
  output logic             tok_end_digit,
  output logic             tok_ovf
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} arb_state_t;
  typedef enum logic [1:0] {START = 2'd0, ID_L = 2'd1, ID_D = 2'd2, BAD = 2'd3} rec_state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  arb_state_t       state, state_next;
  rec_state_t       rec, rec_next;
  logic [LEN_W-1:0] len;
  logic             ovf;
  logic             last_served;
  logic             cur_src, cur_valid, cur_letter, cur_digit, cur_delim;
  logic             delim_fire;
  logic [7:0]       cur_char;

  // The owner's ready is tied high, so any valid character of the owner is consumed.
  assign cur_src    = (state == OWN1);
  assign cur_valid  = ((state == OWN0) && req0_valid) || ((state == OWN1) && req1_valid);
  assign cur_char   = cur_src ? req1_char : req0_char;
  assign cur_letter = (cur_char >= 8'h41) && (cur_char <= 8'h7A);
  assign cur_digit  = (cur_char >= 8'h30) && (cur_char <= 8'h39);
  assign cur_delim  = !(cur_letter || cur_digit);
  assign delim_fire = cur_valid && cur_delim;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of the order the always_ff blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        // last_served=1 means stream 1 went last, so stream 0 wins a tie.
        if (req0_valid && (!req1_valid || last_served)) state_next = OWN0;
        else if (req1_valid)                             state_next = OWN1;
      end
      OWN0, OWN1: if (delim_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    grant      = 2'b00;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      OWN0: begin grant = 2'b01; req0_ready = 1'b1; end
      OWN1: begin grant = 2'b10; req1_ready = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    rec_next = rec;
    case (rec)
      START:      if (cur_letter) rec_next = ID_L; else if (cur_digit) rec_next = BAD;
      ID_L, ID_D: if (cur_letter) rec_next = ID_L; else if (cur_digit) rec_next = ID_D;
      default:    rec_next = BAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rec         <= START;
      len         <= '0;
      ovf         <= 1'b0;
      last_served <= 1'b1;
    end else if (cur_valid) begin
      if (cur_delim) begin
        rec         <= START;
        len         <= '0;
        ovf         <= 1'b0;
        last_served <= cur_src;
      end else begin
        rec <= rec_next;
        if (len == LEN_MAX) ovf <= 1'b1;
        else                len <= len + 1'b1;
      end
    end
  end

  // Report fields are held between reports; only tok_valid pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      tok_valid     <= 1'b0;
      tok_src       <= 1'b0;
      tok_len       <= '0;
      tok_is_id     <= 1'b0;
      tok_end_digit <= 1'b0;
      tok_ovf       <= 1'b0;
    end else begin
      tok_valid <= delim_fire && (len != '0);
      if (delim_fire && (len != '0)) begin
        tok_src       <= cur_src;
        tok_len       <= len;
        tok_is_id     <= (rec == ID_L) || (rec == ID_D);
        tok_end_digit <= (rec == ID_D);
        tok_ovf       <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_id_token_arbiter.sv
// Self-checking bench for id_token_arbiter: directed vector tables, hand sequences
// for multi-cycle corners, and randomized traffic against a token-level model.
module tb_id_token_arbiter;

  localparam int LEN_W = 4;
  localparam int MAXL  = (1 << LEN_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req1_valid;
  logic [7:0]       req0_char, req1_char;
  logic             req0_ready, req1_ready;
  logic [1:0]       grant;
  logic             tok_valid, tok_src, tok_is_id, tok_end_digit, tok_ovf;
  logic [LEN_W-1:0] tok_len;

  int errors = 0;
  int checks = 0;

  id_token_arbiter #(.LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_char(req0_char), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_char(req1_char), .req1_ready(req1_ready),
    .grant(grant), .tok_valid(tok_valid), .tok_src(tok_src), .tok_len(tok_len),
    .tok_is_id(tok_is_id), .tok_end_digit(tok_end_digit), .tok_ovf(tok_ovf)
  );

  always #5 clk = ~clk;

  // Packed view: {grant, r0, r1, tv, src, len[3:0], is_id, end_digit, ovf}
  typedef logic [12:0] obs_t;

  typedef struct {
    bit         rst;
    bit         v0;
    logic [7:0] c0;
    bit         v1;
    logic [7:0] c1;
    obs_t       exp;
  } vec_t;

  vec_t vecs[$];

  function automatic obs_t ex(logic [1:0] g, bit r0, bit r1, bit tv, bit ts,
                              int tl, bit ti, bit te, bit to);
    return {g, r0, r1, tv, ts, LEN_W'(tl), ti, te, to};
  endfunction

  function automatic obs_t get_out();
    return {grant, req0_ready, req1_ready, tok_valid, tok_src, tok_len,
            tok_is_id, tok_end_digit, tok_ovf};
  endfunction

  function automatic vec_t mk(bit rst, bit v0, logic [7:0] c0, bit v1, logic [7:0] c1, obs_t e);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.c0 = c0; v.v1 = v1; v.c1 = c1; v.exp = e;
    return v;
  endfunction

  task automatic check(string name, obs_t actual, obs_t expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %b expected %b (grant,r0,r1,tv,src,len,id,ed,ovf)",
               name, actual, expected);
    end
  endtask

  task automatic drive(bit rst, bit v0, logic [7:0] c0, bit v1, logic [7:0] c1);
    reset = rst; req0_valid = v0; req0_char = c0; req1_valid = v1; req1_char = c1;
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_letter(logic [7:0] c); return c >= 8'h41 && c <= 8'h7A; endfunction
  function automatic bit is_digit(logic [7:0] c);  return c >= 8'h30 && c <= 8'h39; endfunction

  // Token-level reference model: owner, last served stream and the raw token text.
  int         m_own;
  bit         m_last;
  logic [7:0] m_tok[$];
  bit         m_tv, m_ts, m_ti, m_te, m_to;
  int         m_tl;

  task automatic model_edge(bit rst, bit v0, logic [7:0] c0, bit v1, logic [7:0] c1);
    bit         v;
    logic [7:0] c;
    m_tv = 0;
    if (rst) begin
      m_own = -1; m_last = 1; m_tok.delete();
      m_ts = 0; m_tl = 0; m_ti = 0; m_te = 0; m_to = 0;
    end else if (m_own < 0) begin
      if (v0 && (!v1 || m_last)) m_own = 0;
      else if (v1)               m_own = 1;
    end else begin
      v = (m_own == 1) ? v1 : v0;
      c = (m_own == 1) ? c1 : c0;
      if (v) begin
        if (!is_letter(c) && !is_digit(c)) begin
          if (m_tok.size() > 0) begin
            m_tv = 1;
            m_ts = (m_own == 1);
            m_tl = (m_tok.size() > MAXL) ? MAXL : m_tok.size();
            m_to = (m_tok.size() > MAXL);
            m_ti = is_letter(m_tok[0]);
            m_te = m_ti && is_digit(m_tok[m_tok.size()-1]);
          end
          m_tok.delete();
          m_last = (m_own == 1);
          m_own  = -1;
        end else begin
          m_tok.push_back(c);
        end
      end
    end
  endtask

  function automatic obs_t model_obs();
    logic [1:0] g;
    g = (m_own == 0) ? 2'b01 : (m_own == 1) ? 2'b10 : 2'b00;
    return ex(g, m_own == 0, m_own == 1, m_tv, m_ts, m_tl, m_ti, m_te, m_to);
  endfunction

  function automatic logic [7:0] rand_char();
    int k;
    k = $urandom_range(0, 9);
    if (k <= 3)      return 8'($urandom_range(8'h41, 8'h7A));
    else if (k <= 6) return 8'($urandom_range(8'h30, 8'h39));
    else if (k <= 8) return 8'h20;
    else             return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    drive(1, 0, 0, 0, 0);

    // "ab1 " on stream 0
    vecs.push_back(mk(1, 0, 0,   0, 0, ex(2'b00, 0, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 1, "a", 0, 0, ex(2'b01, 1, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 1, "a", 0, 0, ex(2'b01, 1, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 1, "b", 0, 0, ex(2'b01, 1, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 1, "1", 0, 0, ex(2'b01, 1, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 1, " ", 0, 0, ex(2'b00, 0, 0, 1, 0, 3, 1, 1, 0)));
    vecs.push_back(mk(0, 0, 0,   0, 0, ex(2'b00, 0, 0, 0, 0, 3, 1, 1, 0)));
    // tie from reset: "x " then "y ", reports three cycles apart
    vecs.push_back(mk(1, 0, 0,   0, 0,   ex(2'b00, 0, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 1, "x", 1, "y", ex(2'b01, 1, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 1, "x", 1, "y", ex(2'b01, 1, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 1, " ", 1, "y", ex(2'b00, 0, 0, 1, 0, 1, 1, 0, 0)));
    vecs.push_back(mk(0, 0, 0,   1, "y", ex(2'b10, 0, 1, 0, 0, 1, 1, 0, 0)));
    vecs.push_back(mk(0, 0, 0,   1, "y", ex(2'b10, 0, 1, 0, 0, 1, 1, 0, 0)));
    vecs.push_back(mk(0, 0, 0,   1, " ", ex(2'b00, 0, 0, 1, 1, 1, 1, 0, 0)));
    // "9a " is not an identifier; a lone delimiter produces no report
    vecs.push_back(mk(1, 0, 0,   0, 0, ex(2'b00, 0, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 1, "9", 0, 0, ex(2'b01, 1, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 1, "9", 0, 0, ex(2'b01, 1, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 1, "a", 0, 0, ex(2'b01, 1, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 1, " ", 0, 0, ex(2'b00, 0, 0, 1, 0, 2, 0, 0, 0)));
    vecs.push_back(mk(0, 1, " ", 0, 0, ex(2'b01, 1, 0, 0, 0, 2, 0, 0, 0)));
    vecs.push_back(mk(0, 1, " ", 0, 0, ex(2'b00, 0, 0, 0, 0, 2, 0, 0, 0)));
    vecs.push_back(mk(0, 0, 0,   0, 0, ex(2'b00, 0, 0, 0, 0, 2, 0, 0, 0)));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].v0, vecs[i].c0, vecs[i].v1, vecs[i].c1);
      step();
      check($sformatf("vec%0d", i), get_out(), vecs[i].exp);
    end

    // 17 letters on stream 1: length saturates at 15 with overflow
    drive(1, 0, 0, 0, 0); step();
    drive(0, 0, 0, 1, "a"); step();
    check("t4_grant", get_out(), ex(2'b10, 0, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 17; i++) begin
      drive(0, 0, 0, 1, 8'h61 + 8'(i)); step();
    end
    drive(0, 0, 0, 1, " "); step();
    check("t4_report", get_out(), ex(2'b00, 0, 0, 1, 1, 15, 1, 0, 1));

    // stream 0 stalls mid-token while stream 1 waits; ownership is kept
    drive(1, 0, 0, 0, 0); step();
    drive(0, 1, "a", 1, "z"); step();
    check("t5_grant", get_out(), ex(2'b01, 1, 0, 0, 0, 0, 0, 0, 0));
    step();
    drive(0, 1, "b", 1, "z"); step();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 1, "z"); step();
      check($sformatf("t5_stall%0d", i), get_out(), ex(2'b01, 1, 0, 0, 0, 0, 0, 0, 0));
    end
    drive(0, 1, " ", 1, "z"); step();
    check("t5_report", get_out(), ex(2'b00, 0, 0, 1, 0, 2, 1, 0, 0));
    drive(0, 0, 0, 1, "z"); step();
    check("t5_next_rr", get_out(), ex(2'b10, 0, 1, 0, 0, 2, 1, 0, 0));

    // reset mid-token discards the partial token
    drive(1, 0, 0, 0, 0); step();
    drive(0, 0, 0, 1, "a"); step();
    drive(0, 0, 0, 1, "a"); step();
    drive(0, 0, 0, 1, "b"); step();
    drive(0, 0, 0, 1, "c"); step();
    check("t6_owned", get_out(), ex(2'b10, 0, 1, 0, 0, 0, 0, 0, 0));
    drive(1, 0, 0, 1, "d"); step();
    check("t6_reset", get_out(), ex(2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(0, 1, "q", 1, "r"); step();
    check("t6_tie", get_out(), ex(2'b01, 1, 0, 0, 0, 0, 0, 0, 0));

    // randomized traffic against the reference model
    drive(1, 0, 0, 0, 0);
    model_edge(1, 0, 0, 0, 0);
    step();
    check("rnd_reset", get_out(), model_obs());
    for (int n = 0; n < 3000; n++) begin
      bit         r, v0, v1;
      logic [7:0] c0, c1;
      r  = ($urandom_range(0, 299) == 0);
      v0 = ($urandom_range(0, 3) != 0);
      v1 = ($urandom_range(0, 3) != 0);
      c0 = rand_char();
      c1 = rand_char();
      drive(r, v0, c0, v1, c1);
      model_edge(r, v0, c0, v1, c1);
      step();
      check($sformatf("rnd%0d", n), get_out(), model_obs());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
